shm_shift_seq: RTL and testbench
================================

// Module: shm_shift_seq
// PURPOSE
//  Multi-cycle shift/rotate sequencer for the SH datapath. Holds private AR/ARX copies, accepts one
//  shift op via start/busy/done, applies it as a sequence of bounded per-cycle steps
//  (<= STEP_MAX bits each), then presents the result. Sits between EBOX microcode control and SHM.
//  Long (AR!ARX, 72-bit) and short (AR, 36-bit) forms.
// PARAMETERS
//  WORD      36  bits per AR/ARX word; bit 0 = MSB, [0:WORD-1] numbering
//  STEP_MAX  36  max bits shifted per STEP cycle (1..2*WORD)
//  CNT_W     9   width of signed shift count (two's complement, +left / -right)
// PORTS
//  clk       in   1       clock, all state on rising edge
//  reset_n   in   1       async active-low reset
//  start     in   1       request; accepted only in IDLE
//  op        in   3       000 LSH, 001 ROT, 010 LSHC, 011 ROTC, 100 ASH, 101 ASHC; 11x = LSH
//  count     in   CNT_W   signed shift count, sampled with start
//  arIn      in   [0:35]  AR operand, sampled with start
//  arxIn     in   [0:35]  ARX operand, sampled with start (ignored by short ops)
//  AR        out  [0:35]  working/result AR
//  ARX       out  [0:35]  working/result ARX
//  busy      out  1       op in progress (LOAD..DONE inclusive)
//  done      out  1       one-cycle pulse, result valid on AR/ARX this cycle
//  overflow  out  1       ASH/ASHC lost significant bit; valid with done, held until next start
// BEHAVIOUR
//  - Reset: state IDLE; AR, ARX, remaining count = 0; busy, done, overflow = 0. Reset mid-op aborts
//    immediately; no done pulse follows.
//  - States: IDLE -> LOAD -> STEP* -> DONE -> IDLE.
//  - IDLE: start=1 captures op, count, arIn, arxIn; next state LOAD. start ignored when busy=1.
//  - LOAD: W = 36 short, 72 long. mag = |count|. Effective count E:
//      rotates  E = mag mod W, direction = sign(count);
//      shifts   E = min(mag, W).
//    overflow cleared. E==0 -> DONE, else -> STEP.
//  - STEP: k = min(rem, STEP_MAX); shift/rotate working word by k; rem -= k; rem==0 -> DONE.
//  - DONE: done=1 one cycle, busy=1; next IDLE (busy=0). start in DONE cycle ignored.
//  - Latency start->done = 2 + ceil(E/STEP_MAX) cycles; E==0 gives 2.
//  - Logical shifts zero-fill; E==W clears word.
//  - Long forms treat AR!ARX as one 72-bit word, AR[0] MSB, ARX[35] LSB.
//  - count = -2^(CNT_W-1): mag = 2^(CNT_W-1), no wrap error.
//  - Outputs AR/ARX show intermediate values during STEP; consumers sample only at done.
// CONFIGURATION
//  SHM_SHIFT_SEQ_ASH_EN defined: ops 100/101 are arithmetic.
//    ASH: AR[0] preserved; right shift sign-fills; left shift zero-fills AR[1:35];
//    overflow set if any bit shifted out of AR[1] differs from AR[0].
//    ASHC: same on AR[0] + AR[1:35]!ARX[1:35] (70 magnitude bits, W=70);
//    ARX[0] forced = AR[0] at DONE.
//  Not defined: ops 100/101 execute as LSH/LSHC; overflow tied 0.
// TESTING
//  1. LSH AR=000000000001 (octal), count=+1, STEP_MAX=36
//     -> AR=000000000002 at done, done 3 cycles after start.
//  2. ROTC AR=400000000000, ARX=0, count=+72 -> E=0; done 2 cycles after start; AR/ARX unchanged.
//  3. LSH AR=777777777777, count=-40 -> AR=0 at done; 3 cycles.
//  4. STEP_MAX=8, ROT AR=1, count=+20 -> 3 STEP cycles (8,8,4), AR=000004000000, done 5 cycles.
//     start asserted during busy -> ignored.
//  5. reset_n low during STEP of case 4 -> AR=ARX=0, busy=0, no done; fresh start then completes.
//  6. ASH_EN: ASH AR=200000000000, count=+1 -> AR=0, overflow=1;
//     ASH AR=400000000000, count=-3 -> AR=740000000000, overflow=0.
//     Without macro: first case gives AR=400000000000, overflow=0.

Source files
------------

// File: rtl/shm_shift_seq.sv
// shm_shift_seq: multi-cycle shift/rotate sequencer with private AR/ARX copies, bounded bits per step.
// Optional macro SHM_SHIFT_SEQ_ASH_EN turns ops 100/101 into arithmetic ASH/ASHC with overflow.
module shm_shift_seq #(
    parameter int WORD     = 36,
    parameter int STEP_MAX = 36,
    parameter int CNT_W    = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic [0:WORD-1]  arIn,
    input  logic [0:WORD-1]  arxIn,
    output logic [0:WORD-1]  AR,
    output logic [0:WORD-1]  ARX,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    localparam int DW    = 2 * WORD;
    localparam int MW    = DW - 2;
    localparam int QW    = 2 * DW;
    localparam int REM_W = $clog2(DW + 1);
    localparam logic [REM_W-1:0] STEP_K = REM_W'(STEP_MAX);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_DONE} state_t;
    typedef enum logic [2:0] {K_LSH, K_ROT, K_LSHC, K_ROTC, K_ASH, K_ASHC} kind_t;

    state_t           state_reg;
    kind_t            kind_reg;
    kind_t            kind_in;
    logic             left_reg;
    logic [CNT_W-1:0] count_reg;
    logic [0:WORD-1]  ar_reg;
    logic [0:WORD-1]  arx_reg;
    logic [REM_W-1:0] rem_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             ovf_reg;

    logic [CNT_W-1:0] mag;
    int               mag_i;
    int               e_i;
    logic [REM_W-1:0] eff;

    logic [REM_W-1:0] k;
    logic [DW-1:0]    wd_cur;
    logic [DW-1:0]    wd_step;
    logic [WORD-1:0]  a_cur;
    logic [DW-1:0]    short_t;
    logic [2*DW-1:0]  long_t;
    logic             sgn;
    logic [DW-1:0]    mag_ext;
    logic [MW-1:0]    mag_sh;
    logic [QW-1:0]    lost_bits;
    logic [QW-1:0]    lost_mask;
    logic             lost_bad;

    always_comb begin
        case (op)
            3'b001:  kind_in = K_ROT;
            3'b010:  kind_in = K_LSHC;
            3'b011:  kind_in = K_ROTC;
`ifdef SHM_SHIFT_SEQ_ASH_EN
            3'b100:  kind_in = K_ASH;
            3'b101:  kind_in = K_ASHC;
`else
            3'b101:  kind_in = K_LSHC;
`endif
            default: kind_in = K_LSH;
        endcase
    end

    // Rotates reduce modulo the word width; shifts saturate at it (a full-width shift clears).
    always_comb begin
        mag   = count_reg[CNT_W-1] ? -count_reg : count_reg;
        mag_i = int'(mag);
        case (kind_reg)
            K_ROT:   e_i = mag_i % WORD;
            K_ROTC:  e_i = mag_i % DW;
            K_LSHC:  e_i = (mag_i < DW) ? mag_i : DW;
            K_ASHC:  e_i = (mag_i < MW) ? mag_i : MW;
            default: e_i = (mag_i < WORD) ? mag_i : WORD;
        endcase
        eff = REM_W'(e_i);
    end

    always_comb begin
        k         = (rem_reg < STEP_K) ? rem_reg : STEP_K;
        wd_cur    = {ar_reg, arx_reg};
        a_cur     = wd_cur[DW-1:WORD];
        wd_step   = wd_cur;
        short_t   = '0;
        long_t    = '0;
        sgn       = 1'b0;
        mag_ext   = '0;
        mag_sh    = '0;
        lost_bits = '0;
        lost_mask = ~({QW{1'b1}} << k);
        lost_bad  = 1'b0;
        case (kind_reg)
            K_ROT: begin
                short_t = left_reg ? ({a_cur, a_cur} << k) : ({a_cur, a_cur} >> k);
                wd_step = left_reg ? {short_t[DW-1:WORD], wd_cur[WORD-1:0]}
                                   : {short_t[WORD-1:0], wd_cur[WORD-1:0]};
            end
            K_LSHC: wd_step = left_reg ? (wd_cur << k) : (wd_cur >> k);
            K_ROTC: begin
                long_t  = left_reg ? ({wd_cur, wd_cur} << k) : ({wd_cur, wd_cur} >> k);
                wd_step = left_reg ? long_t[2*DW-1:DW] : long_t[DW-1:0];
            end
            // Lost bits are the top k bits pushed past the magnitude; all must equal the sign.
            K_ASH: begin
                sgn       = a_cur[WORD-1];
                mag_ext   = {{(DW-WORD+1){sgn}}, a_cur[WORD-2:0]};
                mag_sh    = left_reg ? MW'(mag_ext << k) : MW'($signed(mag_ext) >>> k);
                wd_step   = {sgn, mag_sh[WORD-2:0], wd_cur[WORD-1:0]};
                lost_bits = (QW'(a_cur[WORD-2:0]) << k) >> (WORD - 1);
                lost_bad  = left_reg && (lost_bits != (sgn ? lost_mask : '0));
            end
            K_ASHC: begin
                sgn       = wd_cur[DW-1];
                mag_ext   = {sgn, sgn, wd_cur[DW-2:WORD], wd_cur[WORD-2:0]};
                mag_sh    = left_reg ? MW'(mag_ext << k) : MW'($signed(mag_ext) >>> k);
                wd_step   = {sgn, mag_sh[MW-1:WORD-1], wd_cur[WORD-1], mag_sh[WORD-2:0]};
                lost_bits = (QW'(mag_ext[MW-1:0]) << k) >> MW;
                lost_bad  = left_reg && (lost_bits != (sgn ? lost_mask : '0));
            end
            default: wd_step = {left_reg ? (a_cur << k) : (a_cur >> k), wd_cur[WORD-1:0]};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            kind_reg  <= K_LSH;
            left_reg  <= 1'b0;
            count_reg <= '0;
            ar_reg    <= '0;
            arx_reg   <= '0;
            rem_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        kind_reg  <= kind_in;
                        count_reg <= count;
                        left_reg  <= ~count[CNT_W-1];
                        ar_reg    <= arIn;
                        arx_reg   <= arxIn;
                        busy_reg  <= 1'b1;
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ovf_reg <= 1'b0;
                    rem_reg <= eff;
                    if (eff == '0) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                        if (kind_reg == K_ASHC) arx_reg[0] <= ar_reg[0];
                    end else begin
                        state_reg <= S_STEP;
                    end
                end
                S_STEP: begin
                    ar_reg  <= wd_step[DW-1:WORD];
                    arx_reg <= wd_step[WORD-1:0];
                    rem_reg <= rem_reg - k;
                    if (lost_bad) ovf_reg <= 1'b1;
                    if (rem_reg == k) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                        if (kind_reg == K_ASHC) arx_reg[0] <= wd_step[DW-1];
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign AR       = ar_reg;
    assign ARX      = arx_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign overflow = ovf_reg;
endmodule

// File: tb/tb_shm_shift_seq.sv
// Bench for shm_shift_seq: two instances (8- and 36-bit step limits) against a bit-serial reference model.
module tb_shm_shift_seq;
`ifdef SHM_SHIFT_SEQ_ASH_EN
    localparam bit ASH_EN = 1'b1;
`else
    localparam bit ASH_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [8:0]  count;
    logic [35:0] ar_in, arx_in;
    logic [35:0] ar_a, arx_a, ar_b, arx_b;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    int          edge_cnt [8] = '{0, 36, -36, 72, -72, 70, -256, 255};

    always #5 clk = ~clk;

    shm_shift_seq #(.WORD(36), .STEP_MAX(36), .CNT_W(9)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .count(count),
        .arIn(ar_in), .arxIn(arx_in), .AR(ar_a), .ARX(arx_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a)
    );

    shm_shift_seq #(.WORD(36), .STEP_MAX(8), .CNT_W(9)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .count(count),
        .arIn(ar_in), .arxIn(arx_in), .AR(ar_b), .ARX(arx_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] rnd36();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[35:0];
    endfunction

    // One bit at a time, E times, straight from the op definitions.
    function automatic void model(input logic [2:0] op_i, input int cnt,
                                  input logic [35:0] a_i, input logic [35:0] x_i,
                                  output logic [35:0] a_o, output logic [35:0] x_o,
                                  output logic ovf_o, output int e_o);
        bit          arith, long_f, rot;
        int          mag, w, n, nw;
        logic [71:0] v;
        logic [69:0] m;
        logic        s, b;
        arith  = ASH_EN && (op_i == 3'd4 || op_i == 3'd5);
        long_f = (op_i == 3'd2) || (op_i == 3'd3) || (op_i == 3'd5);
        rot    = (op_i == 3'd1) || (op_i == 3'd3);
        mag    = (cnt < 0) ? -cnt : cnt;
        w      = long_f ? (arith ? 70 : 72) : 36;
        e_o    = rot ? (mag % w) : ((mag < w) ? mag : w);
        ovf_o  = 1'b0;
        a_o    = a_i;
        x_o    = x_i;
        if (arith) begin
            s = a_i[35];
            n = long_f ? 70 : 35;
            m = long_f ? {a_i[34:0], x_i[34:0]} : {35'b0, a_i[34:0]};
            for (int i = 0; i < e_o; i++) begin
                if (cnt > 0) begin
                    if (m[n-1] != s) ovf_o = 1'b1;
                    m = m << 1;
                    if (n == 35) m[69:35] = '0;
                end else begin
                    m = m >> 1;
                    m[n-1] = s;
                end
            end
            if (long_f) begin
                a_o = {s, m[69:35]};
                x_o = {s, m[34:0]};
            end else begin
                a_o = {s, m[34:0]};
            end
        end else begin
            nw = long_f ? 72 : 36;
            v  = long_f ? {a_i, x_i} : {36'b0, a_i};
            for (int i = 0; i < e_o; i++) begin
                if (cnt > 0) begin
                    b = v[nw-1];
                    v = v << 1;
                    v[0] = rot ? b : 1'b0;
                end else begin
                    b = v[0];
                    v = v >> 1;
                    v[nw-1] = rot ? b : 1'b0;
                end
            end
            a_o = long_f ? v[71:36] : v[35:0];
            if (long_f) x_o = v[35:0];
        end
    endfunction

    // poke > 0 re-asserts start (with junk operands) in that cycle; it must be ignored.
    task automatic run_op(input string tag, input logic [2:0] op_i, input int cnt,
                          input logic [35:0] a_i, input logic [35:0] x_i, input int poke);
        logic [35:0] ea, ex, ra_a, rx_a, ra_b, rx_b;
        logic        eo, ro_a, ro_b;
        int          e, lat_a, lat_b;
        model(op_i, cnt, a_i, x_i, ea, ex, eo, e);
        lat_a = 0; lat_b = 0;
        ra_a = '0; rx_a = '0; ra_b = '0; rx_b = '0; ro_a = 1'b0; ro_b = 1'b0;
        @(negedge clk);
        start = 1'b1; op = op_i; count = cnt[8:0]; ar_in = a_i; arx_in = x_i;
        for (int cyc = 1; cyc <= 40 && (lat_a == 0 || lat_b == 0); cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk({tag, "/A.busy"}, 72'(busy_a), 72'(1));
                chk({tag, "/B.busy"}, 72'(busy_b), 72'(1));
            end
            if (done_a && lat_a == 0) begin
                lat_a = cyc; ra_a = ar_a; rx_a = arx_a; ro_a = ovf_a;
            end
            if (done_b && lat_b == 0) begin
                lat_b = cyc; ra_b = ar_b; rx_b = arx_b; ro_b = ovf_b;
            end
            start = (cyc == poke);
            op = 3'($urandom); count = 9'($urandom); ar_in = rnd36(); arx_in = rnd36();
        end
        @(negedge clk);
        chk({tag, "/idle"}, 72'({busy_a, done_a, busy_b, done_b}), 72'(0));
        start = 1'b0;
        chk({tag, "/A.lat"}, 72'(lat_a), 72'(2 + (e + 35) / 36));
        chk({tag, "/B.lat"}, 72'(lat_b), 72'(2 + (e + 7) / 8));
        chk({tag, "/A.AR"},  72'(ra_a), 72'(ea));
        chk({tag, "/A.ARX"}, 72'(rx_a), 72'(ex));
        chk({tag, "/A.ovf"}, 72'(ro_a), 72'(eo));
        chk({tag, "/B.AR"},  72'(ra_b), 72'(ea));
        chk({tag, "/B.ARX"}, 72'(rx_b), 72'(ex));
        chk({tag, "/B.ovf"}, 72'(ro_b), 72'(eo));
        $display("txn %s op=%0d cnt=%0d E=%0d lat=%0d/%0d AR=%012o ARX=%012o ovf=%0b",
                 tag, op_i, cnt, e, lat_a, lat_b, ra_b, rx_b, ro_b);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] r_op;
        int         r_cnt;
        bit         saw_done;
        reset_n = 1'b0; start = 1'b0; op = '0; count = '0; ar_in = '0; arx_in = '0;
        repeat (3) @(negedge clk);
        chk("rst/A.word",  72'({ar_a, arx_a}), 72'(0));
        chk("rst/B.word",  72'({ar_b, arx_b}), 72'(0));
        chk("rst/flags",   72'({busy_a, done_a, ovf_a, busy_b, done_b, ovf_b}), 72'(0));
        reset_n = 1'b1;
        @(negedge clk);

        run_op("t1_lsh",  3'd0,   1, 36'o000000000001, rnd36(), 3);
        run_op("t2_rotc", 3'd3,  72, 36'o400000000000, 36'o0, 0);
        run_op("t3_lsh",  3'd0, -40, 36'o777777777777, rnd36(), 0);
        run_op("t4_rot",  3'd1,  20, 36'o000000000001, rnd36(), 2);

        // Reset while both instances are mid-STEP: everything clears, no done follows.
        @(negedge clk);
        start = 1'b1; op = 3'd1; count = 9'd20; ar_in = 36'o1; arx_in = rnd36();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t5/B.busy_pre", 72'(busy_b), 72'(1));
        reset_n = 1'b0;
        #1;
        chk("t5/A.word",  72'({ar_a, arx_a}), 72'(0));
        chk("t5/B.word",  72'({ar_b, arx_b}), 72'(0));
        chk("t5/flags",   72'({busy_a, done_a, busy_b, done_b}), 72'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done_a || done_b || busy_a || busy_b) saw_done = 1'b1;
        end
        chk("t5/no_done", 72'(saw_done), 72'(0));
        run_op("t5_fresh", 3'd1, 20, 36'o000000000001, rnd36(), 0);

        run_op("t6_ash_l", 3'd4,   1, 36'o200000000000, 36'o0, 0);
        run_op("t6_ash_r", 3'd4,  -3, 36'o400000000000, 36'o0, 0);
        run_op("ashc_l",   3'd5,   5, 36'o377777777777, rnd36(), 0);
        run_op("ashc_r",   3'd5, -71, 36'o400000000000, rnd36(), 0);
        run_op("min_cnt",  3'd1, -256, rnd36(), rnd36(), 0);
        run_op("lshc_72",  3'd2,  72, rnd36(), rnd36(), 0);

        for (int t = 0; t < 30; t++) begin
            r_op  = 3'($urandom_range(7));
            r_cnt = ($urandom_range(3) == 0) ? edge_cnt[$urandom_range(7)]
                                             : int'($urandom_range(511)) - 256;
            run_op($sformatf("rnd%0d", t), r_op, r_cnt, rnd36(), rnd36(), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
